// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single main-memory line port (I-cache and D-cache).
// Round-robin on simultaneous requests; one transaction in flight, completion returned as a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              owner_d
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              pri_d_q, pri_d_d;
    logic              owner_d_q, owner_d_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;

    logic req_i;
    logic req_d;
    logic grant_d;

    always_comb begin
        state_d     = state_q;
        pri_d_d     = pri_d_q;
        owner_d_d   = owner_d_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        req_i   = i_read | i_write;
        req_d   = d_read | d_write;
        grant_d = req_d & (~req_i | pri_d_q);

        case (state_q)
            ST_IDLE: begin
                if (req_i | req_d) begin
                    owner_d_d   = grant_d;
                    mem_addr_d  = grant_d ? d_addr  : i_addr;
                    mem_wdata_d = grant_d ? d_wdata : i_wdata;
                    // A requester asserting both strobes is treated as a write.
                    mem_write_d = grant_d ? d_write : i_write;
                    mem_read_d  = grant_d ? (d_read & ~d_write) : (i_read & ~i_write);
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    if (owner_d_q) begin
                        d_rdata_d = mem_rdata;
                        d_ready_d = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_ready_d = 1'b1;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                pri_d_d   = ~owner_d_q;
                owner_d_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                owner_d_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pri_d_q     <= 1'b1;
            owner_d_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pri_d_q     <= pri_d_d;
            owner_d_q   <= owner_d_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign owner_d   = owner_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: expected memory transactions are queued as requests are driven and
// checked by a memory responder when the arbiter issues them and when the ready pulse returns.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic              i_ready, d_ready, mem_read, mem_write, mem_ready, owner_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner_d(owner_d)
    );

    typedef struct {
        logic              is_d;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    int   gap_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_resp_cyc = 0;
    int   i_pulses = 0;
    int   d_pulses = 0;
    int   mem_lat = 3;
    bit   mem_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (i_ready) i_pulses <= i_pulses + 1;
        if (d_ready) d_pulses <= d_pulses + 1;
    end

    function automatic txn_t mk(logic is_d, logic wr, logic [ADDR_W-1:0] a,
                                logic [DATA_W-1:0] w, logic [DATA_W-1:0] r);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.addr = a; t.wdata = w; t.rdata = r;
        return t;
    endfunction

    // Memory model: checks each issued transaction against the queue head, checks it is held
    // stable while busy, answers after mem_lat cycles and checks the returned ready/rdata.
    task automatic responder();
        txn_t cur;
        int   phase = 0;
        int   cnt = 0;
        logic [2+ADDR_W+DATA_W:0] snap;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0;
                mem_ready = 1'b0;
            end else if (phase == 2) begin
                mem_ready = 1'b0;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                checks++;
                if ({i_ready, d_ready} !== (cur.is_d ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL resp_ready got i=%b d=%b exp_owner_d=%b", i_ready, d_ready, cur.is_d);
                end
                checks++;
                if ((cur.is_d ? d_rdata : i_rdata) !== cur.rdata) begin
                    failures++;
                    $display("FAIL resp_rdata got=%h exp=%h", cur.is_d ? d_rdata : i_rdata, cur.rdata);
                end
                checks++;
                if ({mem_read, mem_write, owner_d} !== {2'b00, cur.is_d}) begin
                    failures++;
                    $display("FAIL resp_strobes got rd=%b wr=%b own=%b exp rd=0 wr=0 own=%b",
                             mem_read, mem_write, owner_d, cur.is_d);
                end
                last_resp_cyc = cyc;
                done_cnt++;
                phase = 0;
            end else if (phase == 0 && (mem_read || mem_write)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_grant got addr=%h rd=%b wr=%b exp none", mem_addr, mem_read, mem_write);
                    cur = mk(owner_d, mem_write, mem_addr, mem_wdata, '0);
                end else begin
                    cur = exp_q.pop_front();
                    if (owner_d !== cur.is_d || {mem_write, mem_read} !== {cur.wr, ~cur.wr}) begin
                        failures++;
                        $display("FAIL grant_owner_op got own=%b wr=%b rd=%b exp own=%b wr=%b rd=%b",
                                 owner_d, mem_write, mem_read, cur.is_d, cur.wr, ~cur.wr);
                    end
                    checks++;
                    if (mem_addr !== cur.addr || mem_wdata !== cur.wdata) begin
                        failures++;
                        $display("FAIL grant_addr_data got %h/%h exp %h/%h", mem_addr, mem_wdata, cur.addr, cur.wdata);
                    end
                end
                gap_q.push_back(cyc - last_resp_cyc);
                snap = {mem_read, mem_write, owner_d, mem_addr, mem_wdata};
                cnt = 1;
                phase = 1;
            end
            if (rst_n && phase == 1) begin
                if (cnt > 1) begin
                    checks++;
                    if ({mem_read, mem_write, owner_d, mem_addr, mem_wdata} !== snap) begin
                        failures++;
                        $display("FAIL busy_hold cycle=%0d got rd=%b wr=%b addr=%h exp rd=%b wr=%b addr=%h",
                                 cnt, mem_read, mem_write, mem_addr, snap[2+ADDR_W+DATA_W],
                                 snap[1+ADDR_W+DATA_W], snap[ADDR_W+DATA_W-1:DATA_W]);
                    end
                end
                if (!mem_stall && cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = cur.rdata;
                    phase = 2;
                end
                cnt++;
            end
        end
    endtask

    task automatic test_reset();
        int p0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready, owner_d} !== 5'b0 || mem_addr !== '0 ||
            mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL reset_values got rd=%b wr=%b ir=%b dr=%b own=%b addr=%h exp all zero",
                     mem_read, mem_write, i_ready, d_ready, owner_d, mem_addr);
        end
        rst_n = 1'b1;
        // abandon a transaction mid-BUSY
        mem_stall = 1'b1;
        @(posedge clk); #1;
        i_addr = 28'h0ABCDE0; i_wdata = 128'h77;
        exp_q.push_back(mk(1'b0, 1'b0, 28'h0ABCDE0, 128'h77, '0));
        i_read = 1'b1;
        for (int k = 0; k < 20 && !mem_read; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (mem_read !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy_grant got mem_read=%b exp 1", mem_read);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready, owner_d} !== 5'b0) begin
            failures++;
            $display("FAIL reset_async got rd=%b wr=%b ir=%b dr=%b own=%b exp 00000",
                     mem_read, mem_write, i_ready, d_ready, owner_d);
        end
        i_read = 1'b0;
        p0 = i_pulses + d_pulses;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_stall = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (i_pulses + d_pulses != p0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_quiet got pulses=%0d rd=%b wr=%b exp pulses=%0d rd=0 wr=0",
                     i_pulses + d_pulses, mem_read, mem_write, p0);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        base = done_cnt;
        gap_q.delete();
        @(posedge clk); #1;
        i_addr = 28'h0000300; i_wdata = 128'h1111;
        d_addr = 28'h0000200; d_wdata = 128'h2222;
        exp_q.push_back(mk(1'b1, 1'b0, 28'h0000200, 128'h2222, 128'hD0D0_0001));
        exp_q.push_back(mk(1'b0, 1'b0, 28'h0000300, 128'h1111, 128'h1010_0001));
        i_read = 1'b1; d_read = 1'b1;
        for (int k = 0; k < 100 && done_cnt < base + 1; k++) @(posedge clk);
        #1 d_read = 1'b0;
        for (int k = 0; k < 100 && done_cnt < base + 2; k++) @(posedge clk);
        #1 i_read = 1'b0;
        checks++;
        if (done_cnt != base + 2 || gap_q.size() != 2 || gap_q[1] != 2) begin
            failures++;
            $display("FAIL sim_pair_gap got done=%0d grants=%0d exp done=%0d grants=2 gap=2",
                     done_cnt - base, gap_q.size(), 2);
        end
        // D alone, then a pair: I now has priority
        d_addr = 28'h0000210;
        exp_q.push_back(mk(1'b1, 1'b0, 28'h0000210, 128'h2222, 128'hD0D0_0002));
        d_read = 1'b1;
        for (int k = 0; k < 100 && done_cnt < base + 3; k++) @(posedge clk);
        #1 d_read = 1'b0;
        i_addr = 28'h0000310; d_addr = 28'h0000220;
        exp_q.push_back(mk(1'b0, 1'b0, 28'h0000310, 128'h1111, 128'h1010_0002));
        exp_q.push_back(mk(1'b1, 1'b0, 28'h0000220, 128'h2222, 128'hD0D0_0003));
        i_read = 1'b1; d_read = 1'b1;
        for (int k = 0; k < 100 && done_cnt < base + 4; k++) @(posedge clk);
        #1 i_read = 1'b0;
        for (int k = 0; k < 100 && done_cnt < base + 5; k++) @(posedge clk);
        #1 d_read = 1'b0;
        checks++;
        if (done_cnt != base + 5 || gap_q.size() != 5 || gap_q[3] != 2 || gap_q[4] != 2) begin
            failures++;
            $display("FAIL sim_rr_gap got done=%0d grants=%0d exp done=5 grants=5 gap=2",
                     done_cnt - base, gap_q.size());
        end
    endtask

    task automatic test_single_i_read();
        int base, ip, dp;
        base = done_cnt; ip = i_pulses; dp = d_pulses;
        mem_lat = 5;
        @(posedge clk); #1;
        i_addr = 28'h0000040; i_wdata = 128'h0;
        exp_q.push_back(mk(1'b0, 1'b0, 28'h0000040, 128'h0, 128'hDEADBEEF_00112233_44556677_8899AA01));
        i_read = 1'b1;
        for (int k = 0; k < 100 && done_cnt < base + 1; k++) @(posedge clk);
        #1 i_read = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != base + 1 || i_pulses != ip + 1 || d_pulses != dp) begin
            failures++;
            $display("FAIL i_read_pulses got done=%0d i=%0d d=%0d exp done=1 i=1 d=0",
                     done_cnt - base, i_pulses - ip, d_pulses - dp);
        end
        checks++;
        if (i_rdata !== 128'hDEADBEEF_00112233_44556677_8899AA01) begin
            failures++;
            $display("FAIL i_rdata_hold got=%h exp=%h", i_rdata, 128'hDEADBEEF_00112233_44556677_8899AA01);
        end
        mem_lat = 3;
    endtask

    task automatic test_d_writeback();
        int base, ip, dp;
        base = done_cnt; ip = i_pulses; dp = d_pulses;
        @(posedge clk); #1;
        d_addr = 28'h0000100; d_wdata = {4{32'hA5A5A5A5}};
        exp_q.push_back(mk(1'b1, 1'b1, 28'h0000100, {4{32'hA5A5A5A5}}, 128'h5A5A));
        d_write = 1'b1;
        for (int k = 0; k < 100 && done_cnt < base + 1; k++) @(posedge clk);
        #1 d_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != base + 1 || d_pulses != dp + 1 || i_pulses != ip) begin
            failures++;
            $display("FAIL d_wb_pulses got done=%0d d=%0d i=%0d exp done=1 d=1 i=0",
                     done_cnt - base, d_pulses - dp, i_pulses - ip);
        end
    endtask

    task automatic test_back_to_back();
        int base, dp;
        base = done_cnt; dp = d_pulses;
        gap_q.delete();
        @(posedge clk); #1;
        d_addr = 28'h0000180; d_wdata = 128'hC0FFEE;
        exp_q.push_back(mk(1'b1, 1'b1, 28'h0000180, 128'hC0FFEE, 128'hBB01));
        d_write = 1'b1;
        for (int k = 0; k < 100 && done_cnt < base + 1; k++) @(posedge clk);
        #1;
        d_write = 1'b0; d_read = 1'b1; d_addr = 28'h00002C0;
        exp_q.push_back(mk(1'b1, 1'b0, 28'h00002C0, 128'hC0FFEE, 128'hBB02));
        for (int k = 0; k < 100 && done_cnt < base + 2; k++) @(posedge clk);
        #1 d_read = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != base + 2 || d_pulses != dp + 2 || gap_q.size() != 2 || gap_q[1] != 2) begin
            failures++;
            $display("FAIL b2b_count got done=%0d d=%0d grants=%0d exp done=2 d=2 grants=2 gap=2",
                     done_cnt - base, d_pulses - dp, gap_q.size());
        end
    endtask

    task automatic test_mid_drop();
        int base, ip;
        base = done_cnt; ip = i_pulses;
        mem_lat = 6;
        @(posedge clk); #1;
        i_addr = 28'h0000500; i_wdata = 128'h9;
        exp_q.push_back(mk(1'b0, 1'b0, 28'h0000500, 128'h9, 128'hFACE));
        i_read = 1'b1;
        for (int k = 0; k < 20 && !mem_read; k++) begin
            @(posedge clk); #1;
        end
        i_read = 1'b0;
        for (int k = 0; k < 100 && done_cnt < base + 1; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != base + 1 || i_pulses != ip + 1) begin
            failures++;
            $display("FAIL mid_drop got done=%0d i=%0d exp done=1 i=1", done_cnt - base, i_pulses - ip);
        end
        mem_lat = 3;
    endtask

    task automatic test_write_wins();
        int base;
        base = done_cnt;
        @(posedge clk); #1;
        i_addr = 28'h0000600; i_wdata = 128'h4242;
        exp_q.push_back(mk(1'b0, 1'b1, 28'h0000600, 128'h4242, 128'h77));
        i_read = 1'b1; i_write = 1'b1;
        for (int k = 0; k < 100 && done_cnt < base + 1; k++) @(posedge clk);
        #1 begin i_read = 1'b0; i_write = 1'b0; end
        checks++;
        if (done_cnt != base + 1) begin
            failures++;
            $display("FAIL write_wins_done got=%0d exp=1", done_cnt - base);
        end
    endtask

    task automatic test_stray_ready();
        int p0;
        logic [DATA_W-1:0] ir, dr;
        p0 = i_pulses + d_pulses; ir = i_rdata; dr = d_rdata;
        @(posedge clk); #1;
        mem_rdata = 128'hBAD;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (i_pulses + d_pulses != p0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
            i_rdata !== ir || d_rdata !== dr) begin
            failures++;
            $display("FAIL stray_ready got pulses=%0d rd=%b wr=%b irdata=%h exp pulses=%0d rd=0 wr=0 irdata=%h",
                     i_pulses + d_pulses, mem_read, mem_write, i_rdata, p0, ir);
        end
    endtask

    initial begin
        i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        fork
            responder();
        join_none
        test_reset();
        test_simultaneous();
        test_single_i_read();
        test_d_writeback();
        test_back_to_back();
        test_mid_drop();
        test_write_wins();
        test_stray_ready();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expected got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
